// File: rtl/timer_int_ctrl.sv
// -----------------------------------------------------------------------------
// timer_int_ctrl
//
// Receives the timer's overflow/underflow trigger pulses and holds them as
// sticky status bits. An APB slave port gives access to the enable and
// status registers. The block drives a masked level interrupt, and it sends
// one-cycle clear pulses back to the trigger source whenever software clears
// a status bit.
//
// Parameters
//   ADDR_W   APB address width (at least 4)
//   WAIT_ST  wait states before pready: 0 or 1
//
// Build option
//   TMR_MISS_CNT_EN  When defined, adds the TMCNT register at offset 0x0C.
//                    It holds two saturating 4-bit counters that count
//                    trigger pulses arriving while the status bit is
//                    already set. When not defined, 0x0C is an unmapped
//                    address.
//
// Ports
//   pclk, preset_n        APB clock; asynchronous active-low reset
//   psel, penable, pwrite APB control
//   paddr, pwdata         byte address (bits [1:0] ignored), write data
//   prdata, pready        read data, valid in the single pready cycle
//   pslverr               unmapped offset, asserted together with pready
//   ovf_trig, udf_trig    single-cycle event pulses from the timer
//   trig_clr              [0]=ovf, [1]=udf one-cycle clear pulses to source
//   tmr_irq               registered |(status & enable)
//
// Register map
//   0x00 TIER  RW   [1:0] = {udf_ie, ovf_ie}
//   0x04 TISR  W1C  [1:0] = {udf_st, ovf_st}
//   0x08 TIMSR RO   TISR & TIER
//   0x0C TMCNT RO   {udf_miss, ovf_miss}; any write clears both counters
// -----------------------------------------------------------------------------
module timer_int_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int WAIT_ST = 1
) (
  input  logic              pclk,
  input  logic              preset_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [7:0]        pwdata,
  output logic [7:0]        prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic              ovf_trig,
  input  logic              udf_trig,
  output logic [1:0]        trig_clr,
  output logic              tmr_irq
);

  // ST_ACCESS: the setup phase has been seen and we are waiting out the
  //            first access cycle (used only when WAIT_ST=1).
  // ST_DONE:   the cycle in which pready is high.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } apb_state_e;

  apb_state_e        state_q, state_d;
  logic [1:0]        ie_q, ie_d;
  logic [1:0]        st_q, st_d;
  logic [1:0]        trig_clr_q, trig_clr_d;
  logic [7:0]        prdata_q, prdata_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;
  logic              irq_q, irq_d;

  logic [ADDR_W-3:0] word_idx;
  logic              sel_tier, sel_tisr, sel_timsr, sel_tmcnt, mapped;
  logic              do_xfer, wr_en;
  logic [1:0]        w1c_mask;
  logic [7:0]        rd_val, tmcnt_val;
  logic              unused_ok;

  assign word_idx  = paddr[ADDR_W-1:2];
  assign sel_tier  = (word_idx == (ADDR_W-2)'(0));
  assign sel_tisr  = (word_idx == (ADDR_W-2)'(1));
  assign sel_timsr = (word_idx == (ADDR_W-2)'(2));
  assign mapped    = sel_tier | sel_tisr | sel_timsr | sel_tmcnt;
  assign unused_ok = ^{paddr[1:0], pwdata[7:2]};

  // APB sequencing. The registered pready is raised at the clock edge where
  // the transfer takes effect. The register update and the prdata capture
  // both happen at that same edge.
  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave a value held (that would infer a latch).
  always_comb begin
    state_d = state_q;
    do_xfer = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (psel && !penable) begin
          if (WAIT_ST == 0) begin
            do_xfer = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_ACCESS;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (!psel) begin
          state_d = ST_IDLE;          // master aborted: no write, no pready
        end else if (penable) begin
          do_xfer = 1'b1;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_en    = do_xfer & pwrite;
    w1c_mask = (wr_en && sel_tisr) ? pwdata[1:0] : 2'b00;

    ie_d = (wr_en && sel_tier) ? pwdata[1:0] : ie_q;

    // OR-ing in the trigger after the clear is what makes a same-cycle set
    // win over a W1C. The clear pulse to the source still goes out.
    st_d       = (st_q & ~w1c_mask) | {udf_trig, ovf_trig};
    trig_clr_d = w1c_mask;
    irq_d      = |(st_q & ie_q);

    rd_val = 8'h00;
    if (sel_tier) begin
      rd_val = {6'b0, ie_q};
    end else if (sel_tisr) begin
      rd_val = {6'b0, st_q};
    end else if (sel_timsr) begin
      rd_val = {6'b0, st_q & ie_q};
    end else if (sel_tmcnt) begin
      rd_val = tmcnt_val;
    end

    pready_d  = do_xfer;
    pslverr_d = do_xfer & ~mapped;
    prdata_d  = prdata_q;
    if (do_xfer) begin
      prdata_d = (!pwrite && mapped) ? rd_val : 8'h00;
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of order.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q    <= ST_IDLE;
      ie_q       <= 2'b00;
      st_q       <= 2'b00;
      trig_clr_q <= 2'b00;
      prdata_q   <= 8'h00;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ie_q       <= ie_d;
      st_q       <= st_d;
      trig_clr_q <= trig_clr_d;
      prdata_q   <= prdata_d;
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
      irq_q      <= irq_d;
    end
  end

`ifdef TMR_MISS_CNT_EN
  logic [3:0] ovf_miss_q, ovf_miss_d;
  logic [3:0] udf_miss_q, udf_miss_d;
  logic       cnt_wipe;

  assign sel_tmcnt = (word_idx == (ADDR_W-2)'(3));
  assign tmcnt_val = {udf_miss_q, ovf_miss_q};

  // A miss is a trigger that arrives while its status bit is already set.
  // The check uses st_q, so a trigger that collides with a W1C still counts.
  // A write to TMCNT takes priority over an increment in the same cycle.
  always_comb begin
    cnt_wipe   = wr_en & sel_tmcnt;
    ovf_miss_d = ovf_miss_q;
    udf_miss_d = udf_miss_q;
    if (cnt_wipe) begin
      ovf_miss_d = 4'h0;
      udf_miss_d = 4'h0;
    end else begin
      if (ovf_trig && st_q[0] && (ovf_miss_q != 4'hF)) ovf_miss_d = ovf_miss_q + 4'd1;
      if (udf_trig && st_q[1] && (udf_miss_q != 4'hF)) udf_miss_d = udf_miss_q + 4'd1;
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      ovf_miss_q <= 4'h0;
      udf_miss_q <= 4'h0;
    end else begin
      ovf_miss_q <= ovf_miss_d;
      udf_miss_q <= udf_miss_d;
    end
  end
`else
  assign sel_tmcnt = 1'b0;
  assign tmcnt_val = 8'h00;
`endif

  assign prdata   = prdata_q;
  assign pready   = pready_q;
  assign pslverr  = pslverr_q;
  assign trig_clr = trig_clr_q;
  assign tmr_irq  = irq_q;

endmodule

// File: tb/tb_timer_int_ctrl.sv
// -----------------------------------------------------------------------------
// tb_timer_int_ctrl
//
// Testbench for timer_int_ctrl with the default WAIT_ST=1.
//
// A single driver process owns every DUT input. It runs directed sequences
// first and then randomized APB traffic mixed with random trigger pulses.
//
// A reference model samples the same inputs at each rising edge. It holds the
// register contents as plain variables, applies the register-map rules, and
// pushes the expected response of each transfer into a queue. A separate
// monitor pops that queue whenever pready is seen. Every cycle, the monitor
// also compares tmr_irq and trig_clr against the model.
// -----------------------------------------------------------------------------
module tb_timer_int_ctrl;

  localparam int ADDR_W  = 8;
  localparam int WAIT_ST = 1;
`ifdef TMR_MISS_CNT_EN
  localparam bit MISS_EN = 1'b1;
`else
  localparam bit MISS_EN = 1'b0;
`endif

  logic        pclk, preset_n;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr, pwdata, prdata;
  logic        pready, pslverr;
  logic        ovf_trig, udf_trig;
  logic [1:0]  trig_clr;
  logic        tmr_irq;

  timer_int_ctrl #(.ADDR_W(ADDR_W), .WAIT_ST(WAIT_ST)) dut (
    .pclk     (pclk),
    .preset_n (preset_n),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .prdata   (prdata),
    .pready   (pready),
    .pslverr  (pslverr),
    .ovf_trig (ovf_trig),
    .udf_trig (udf_trig),
    .trig_clr (trig_clr),
    .tmr_irq  (tmr_irq)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       err;
    logic       is_rd;
    logic       fix_chk;
    logic [7:0] fix_val;
  } resp_t;

  resp_t sb_q[$];

  // Set by the driver for the cycle whose closing edge is the transfer edge.
  logic       xfer_flag = 1'b0;
  logic       dir_chk   = 1'b0;
  logic [7:0] dir_val   = 8'h00;
  logic       rand_en   = 1'b0;

  // ----------------------------------------------------------- reference model
  logic [1:0] m_ie, m_st, m_t, m_clr, m_ie_nxt;
  int         m_ovf_miss, m_udf_miss, m_off;
  logic       m_wipe, m_mapped;
  logic       exp_irq;
  logic [1:0] exp_trig_clr;
  resp_t      m_r;

  always @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      m_ie = 2'b00; m_st = 2'b00;
      m_ovf_miss = 0; m_udf_miss = 0;
      exp_irq = 1'b0; exp_trig_clr = 2'b00;
    end else begin
      m_t      = {udf_trig, ovf_trig};
      m_clr    = 2'b00;
      m_ie_nxt = m_ie;
      m_wipe   = 1'b0;
      // The interrupt seen after this edge reflects the registers before it.
      exp_irq  = |(m_st & m_ie);
      if (xfer_flag) begin
        m_off     = int'(paddr[7:2]);
        m_mapped  = (m_off <= 2) || (MISS_EN && m_off == 3);
        m_r.err     = !m_mapped;
        m_r.is_rd   = !pwrite;
        m_r.fix_chk = dir_chk;
        m_r.fix_val = dir_val;
        m_r.data    = 8'h00;
        if (m_mapped && !pwrite) begin
          case (m_off)
            0: m_r.data = {6'b0, m_ie};
            1: m_r.data = {6'b0, m_st};
            2: m_r.data = {6'b0, m_st & m_ie};
            default: m_r.data = {4'(m_udf_miss), 4'(m_ovf_miss)};
          endcase
        end
        if (m_mapped && pwrite) begin
          case (m_off)
            0: m_ie_nxt = pwdata[1:0];
            1: m_clr    = pwdata[1:0];
            3: m_wipe   = 1'b1;
            default: ;
          endcase
        end
        sb_q.push_back(m_r);
      end
      if (m_t[0] && m_st[0]) m_ovf_miss = (m_ovf_miss < 15) ? m_ovf_miss + 1 : 15;
      if (m_t[1] && m_st[1]) m_udf_miss = (m_udf_miss < 15) ? m_udf_miss + 1 : 15;
      if (m_wipe) begin
        m_ovf_miss = 0;
        m_udf_miss = 0;
      end
      m_st         = (m_st & ~m_clr) | m_t;
      m_ie         = m_ie_nxt;
      exp_trig_clr = m_clr;
    end
  end

  // ------------------------------------------------------------------ monitor
  initial begin
    resp_t r;
    forever begin
      @(negedge pclk);
      if (preset_n) begin
        check("tmr_irq", 32'(tmr_irq), 32'(exp_irq));
        check("trig_clr", 32'(trig_clr), 32'(exp_trig_clr));
        if (pready) begin
          if (sb_q.size() == 0) begin
            check("pready_unexpected", 32'(pready), 32'd0);
          end else begin
            r = sb_q.pop_front();
            check("pslverr", 32'(pslverr), 32'(r.err));
            if (r.is_rd || r.err) check("prdata", 32'(prdata), 32'(r.data));
            if (r.fix_chk) check("prdata_directed", 32'(prdata), 32'(r.fix_val));
          end
        end
      end
    end
  end

  // ------------------------------------------------------------------- driver
  task automatic next_cycle(input logic [1:0] force_t);
    logic [1:0] t;
    @(negedge pclk);
    xfer_flag = 1'b0;
    dir_chk   = 1'b0;
    t = 2'b00;
    if (rand_en) begin
      t[0] = ($urandom_range(0, 3) == 0);
      t[1] = ($urandom_range(0, 3) == 0);
    end
    {udf_trig, ovf_trig} = t | force_t;
  endtask

  task automatic idle(input int n);
    repeat (n) next_cycle(2'b00);
  endtask

  // One APB transfer. coll is pulsed on the triggers in the cycle that ends
  // at the transfer edge.
  task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [7:0] data,
                          input logic fchk, input logic [7:0] fval, input logic [1:0] coll);
    int waited;
    next_cycle(2'b00);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    next_cycle(coll);
    penable   = 1'b1;
    xfer_flag = 1'b1;
    dir_chk   = fchk;
    dir_val   = fval;
    next_cycle(2'b00);
    waited = 0;
    while (!pready && waited < 4) begin
      next_cycle(2'b00);
      waited++;
    end
    check("pready_latency", 32'(waited), 32'd0);
    next_cycle(2'b00);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic apb_wr(input logic [7:0] addr, input logic [7:0] data);
    apb_xfer(1'b1, addr, data, 1'b0, 8'h00, 2'b00);
  endtask

  task automatic apb_rd_exp(input logic [7:0] addr, input logic [7:0] val);
    apb_xfer(1'b0, addr, 8'h00, 1'b1, val, 2'b00);
  endtask

  initial begin
    preset_n = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 8'h00; pwdata = 8'h00;
    ovf_trig = 1'b0; udf_trig = 1'b0;

    repeat (3) @(negedge pclk);
    check("rst_prdata",   32'(prdata),   32'd0);
    check("rst_pready",   32'(pready),   32'd0);
    check("rst_pslverr",  32'(pslverr),  32'd0);
    check("rst_trig_clr", 32'(trig_clr), 32'd0);
    check("rst_tmr_irq",  32'(tmr_irq),  32'd0);
    preset_n = 1'b1;
    idle(2);

    // Registers read zero after reset.
    apb_rd_exp(8'h00, 8'h00);
    apb_rd_exp(8'h04, 8'h00);
    apb_rd_exp(8'h08, 8'h00);

    // Enable both bits; an ovf pulse raises status, masked status and irq.
    apb_wr(8'h00, 8'h03);
    next_cycle(2'b01);
    idle(2);
    apb_rd_exp(8'h04, 8'h01);
    apb_rd_exp(8'h08, 8'h01);
    check("irq_after_ovf", 32'(tmr_irq), 32'd1);

    // W1C of bit 0 clears status, pulses trig_clr[0], drops irq.
    apb_wr(8'h04, 8'h01);
    idle(1);
    check("irq_after_w1c", 32'(tmr_irq), 32'd0);
    apb_rd_exp(8'h04, 8'h00);

    // Writing zero to TISR has no effect.
    next_cycle(2'b10);
    idle(1);
    apb_wr(8'h04, 8'h00);
    apb_rd_exp(8'h04, 8'h02);
    apb_wr(8'h04, 8'h02);

    // Set wins over a same-cycle W1C; trig_clr still pulses.
    next_cycle(2'b01);
    idle(1);
    apb_xfer(1'b1, 8'h04, 8'h01, 1'b0, 8'h00, 2'b01);
    apb_rd_exp(8'h04, 8'h01);

    // Unmapped offset: error, zero data, no state change. TIMSR writes ignored.
    apb_wr(8'h10, 8'hFF);
    apb_rd_exp(8'h10, 8'h00);
    apb_wr(8'h08, 8'hFF);
    apb_rd_exp(8'h00, 8'h03);
    apb_rd_exp(8'h04, 8'h01);

`ifdef TMR_MISS_CNT_EN
    apb_wr(8'h04, 8'h03);
    apb_wr(8'h0C, 8'h00);
    repeat (3) begin
      next_cycle(2'b10);
      next_cycle(2'b00);
    end
    apb_rd_exp(8'h0C, 8'h20);
    apb_wr(8'h0C, 8'h5A);
    repeat (20) begin
      next_cycle(2'b10);
      next_cycle(2'b00);
    end
    apb_rd_exp(8'h0C, 8'hF0);
    // An increment in the same cycle as the clear is lost.
    apb_xfer(1'b1, 8'h0C, 8'hA5, 1'b0, 8'h00, 2'b10);
    apb_rd_exp(8'h0C, 8'h00);
`else
    apb_rd_exp(8'h0C, 8'h00);
`endif

    // Master drops psel during the first access cycle: no write, no pready.
    next_cycle(2'b00);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'h00;
    next_cycle(2'b00);
    psel = 1'b0;
    repeat (3) begin
      next_cycle(2'b00);
      check("abort_pready", 32'(pready), 32'd0);
    end
    apb_rd_exp(8'h00, 8'h03);

    // Randomized traffic with random trigger pulses.
    rand_en = 1'b1;
    for (int i = 0; i < 250; i++) begin
      logic [7:0] a;
      case ($urandom_range(0, 5))
        0, 1, 2, 3: a = 8'(($urandom_range(0, 3) * 4) + $urandom_range(0, 3));
        4:          a = 8'h0C | 8'($urandom_range(0, 3));
        default:    a = 8'($urandom_range(0, 255));
      endcase
      apb_xfer(1'($urandom_range(0, 1)), a, 8'($urandom_range(0, 255)), 1'b0, 8'h00, 2'b00);
      idle($urandom_range(0, 2));
    end
    rand_en = 1'b0;
    idle(3);

    // Asynchronous reset in the middle of a transfer.
    apb_wr(8'h00, 8'h03);
    next_cycle(2'b01);
    idle(2);
    apb_rd_exp(8'h00, 8'h03);
    check("irq_before_reset", 32'(tmr_irq), 32'd1);
    next_cycle(2'b00);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h04; pwdata = 8'h03;
    #2 preset_n = 1'b0;
    #1;
    check("async_rst_prdata",   32'(prdata),   32'd0);
    check("async_rst_pready",   32'(pready),   32'd0);
    check("async_rst_pslverr",  32'(pslverr),  32'd0);
    check("async_rst_trig_clr", 32'(trig_clr), 32'd0);
    check("async_rst_tmr_irq",  32'(tmr_irq),  32'd0);
    next_cycle(2'b00);
    psel = 1'b0; penable = 1'b0;
    next_cycle(2'b00);
    preset_n = 1'b1;
    idle(2);
    apb_rd_exp(8'h00, 8'h00);
    apb_rd_exp(8'h04, 8'h00);

    idle(3);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
